// File: rtl/key_decoder_if.sv
// key_decoder_if: scan-code byte stream in, movement/action requests out
interface key_decoder_if;
  logic [7:0] byteIn;
  logic       byteValid;
  logic       leftPress;
  logic       rightPress;
  logic       startPulse;
  logic       shootPulse;
  modport master (output byteIn, byteValid, input leftPress, rightPress, startPulse, shootPulse);
  modport slave  (input byteIn, byteValid, output leftPress, rightPress, startPulse, shootPulse);
endinterface

// File: rtl/key_decoder.sv
// key_decoder: PS/2 scan-code prefix FSM turning arrows/Enter/Space into game requests
module key_decoder #(
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter logic [7:0] START_CODE     = 8'h5A,
  parameter logic [7:0] SHOOT_CODE     = 8'h29,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input logic          clk,
  input logic          resetN,
  key_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} stateT;
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);
  stateT       state, nextState;
  logic [15:0] count, nextCount;
  logic leftHeld, rightHeld, startHeld, shootHeld, lastLeft;
  logic nLeftHeld, nRightHeld, nStartHeld, nShootHeld, nLastLeft;
  logic leftPressQ, rightPressQ, startPulseQ, shootPulseQ;
  logic nLeftPress, nRightPress, nStartPulse, nShootPulse;
  logic isE0, isF0, extMake, extBrk, nonMake, nonBrk;
  logic isLeft, isRight, isStart, isShoot;
  assign isE0    = bus.byteIn == 8'hE0;
  assign isF0    = bus.byteIn == 8'hF0;
  assign isLeft  = bus.byteIn == LEFT_CODE;
  assign isRight = bus.byteIn == RIGHT_CODE;
  assign isStart = bus.byteIn == START_CODE;
  assign isShoot = bus.byteIn == SHOOT_CODE;
  assign extMake = bus.byteValid && state == EXT && !isE0 && !isF0;
  assign extBrk  = bus.byteValid && state == EXT_BRK;
  assign nonMake = bus.byteValid && state == IDLE && !isE0 && !isF0;
  assign nonBrk  = bus.byteValid && state == BRK;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      count       <= '0;
      leftHeld    <= 1'b0;
      rightHeld   <= 1'b0;
      startHeld   <= 1'b0;
      shootHeld   <= 1'b0;
      lastLeft    <= 1'b0;
      leftPressQ  <= 1'b0;
      rightPressQ <= 1'b0;
      startPulseQ <= 1'b0;
      shootPulseQ <= 1'b0;
    end else begin
      state       <= nextState;
      count       <= nextCount;
      leftHeld    <= nLeftHeld;
      rightHeld   <= nRightHeld;
      startHeld   <= nStartHeld;
      shootHeld   <= nShootHeld;
      lastLeft    <= nLastLeft;
      leftPressQ  <= nLeftPress;
      rightPressQ <= nRightPress;
      startPulseQ <= nStartPulse;
      shootPulseQ <= nShootPulse;
    end
  end
  // a byte arriving on the timeout cycle wins over the timeout
  always_comb begin
    nextState = state;
    nextCount = '0;
    if (bus.byteValid) begin
      case (state)
        IDLE:    nextState = isE0 ? EXT : isF0 ? BRK : IDLE;
        EXT:     nextState = isF0 ? EXT_BRK : isE0 ? EXT : IDLE;
        default: nextState = IDLE;
      endcase
    end else if (state != IDLE) begin
      nextState = count == LAST_COUNT ? IDLE : state;
      nextCount = count == LAST_COUNT ? '0 : count + 16'd1;
    end
  end
  always_comb begin
    nLeftHeld   = extMake && isLeft  ? 1'b1 : extBrk && isLeft  ? 1'b0 : leftHeld;
    nRightHeld  = extMake && isRight ? 1'b1 : extBrk && isRight ? 1'b0 : rightHeld;
    nLastLeft   = extMake && isLeft  ? 1'b1 : extMake && isRight ? 1'b0 : lastLeft;
    nStartHeld  = nonMake && isStart ? 1'b1 : nonBrk && isStart ? 1'b0 : startHeld;
    nShootHeld  = nonMake && isShoot ? 1'b1 : nonBrk && isShoot ? 1'b0 : shootHeld;
    nStartPulse = nonMake && isStart && !startHeld;
    nShootPulse = nonMake && isShoot && !shootHeld;
    nLeftPress  = nLeftHeld && (!nRightHeld || nLastLeft);
    nRightPress = nRightHeld && (!nLeftHeld || !nLastLeft);
  end
  assign bus.leftPress  = leftPressQ;
  assign bus.rightPress = rightPressQ;
  assign bus.startPulse = startPulseQ;
  assign bus.shootPulse = shootPulseQ;
endmodule

// File: tb/tb_key_decoder.sv
// tb_key_decoder: directed scan-code sequences with hand-computed output expectations
module tb_key_decoder;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int checks = 0;
  int errors = 0;
  key_decoder_if bus ();
  key_decoder #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .resetN(resetN), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.leftPress, bus.rightPress, bus.startPulse, bus.shootPulse};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (L R St Sh)", tag, obs, exp);
    end
  endtask
  task automatic sendByte(input logic [7:0] b);
    bus.byteIn = b;
    bus.byteValid = 1'b1;
    @(negedge clk);
    bus.byteValid = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  always @(negedge clk) if (resetN) begin
    checks++;
    assert (!(bus.leftPress && bus.rightPress)) else begin
      errors++;
      $error("FAIL exclusive observed=11 expected=not both");
    end
  end
  initial begin
    bus.byteIn = 8'h00;
    bus.byteValid = 1'b0;
    idle(2);
    chk("reset", 4'b0000);
    resetN = 1'b1;
    idle(1);
    chk("after_release", 4'b0000);
    sendByte(8'hE0); sendByte(8'h74);
    chk("right_make", 4'b0100);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
    chk("right_break", 4'b0000);
    sendByte(8'hE0); sendByte(8'h6B);
    chk("left_make", 4'b1000);
    sendByte(8'hE0); sendByte(8'h74);
    chk("both_last_right", 4'b0100);
    sendByte(8'hE0); sendByte(8'h6B);
    chk("typematic_left_redir", 4'b1000);
    sendByte(8'hE0); sendByte(8'h74);
    chk("redir_right", 4'b0100);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
    chk("right_release_left", 4'b1000);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
    chk("all_released", 4'b0000);
    sendByte(8'h5A);
    chk("start_pulse1", 4'b0010);
    sendByte(8'h5A);
    chk("start_repeat1", 4'b0000);
    sendByte(8'h5A);
    chk("start_repeat2", 4'b0000);
    sendByte(8'hF0); sendByte(8'h5A);
    chk("start_break", 4'b0000);
    sendByte(8'h5A);
    chk("start_pulse2", 4'b0010);
    idle(1);
    chk("start_pulse2_width", 4'b0000);
    sendByte(8'h29);
    chk("shoot_pulse", 4'b0001);
    sendByte(8'h29);
    chk("shoot_repeat", 4'b0000);
    sendByte(8'hF0); sendByte(8'h29); sendByte(8'h29);
    chk("shoot_again", 4'b0001);
    sendByte(8'hF0); sendByte(8'h29); sendByte(8'hF0); sendByte(8'h5A);
    sendByte(8'h6B);
    chk("keypad_left_ignored", 4'b0000);
    sendByte(8'hE0); sendByte(8'h5A);
    chk("ext_enter_ignored", 4'b0000);
    sendByte(8'h5A);
    chk("enter_still_fresh", 4'b0010);
    sendByte(8'hF0); sendByte(8'h5A);
    sendByte(8'hE0); idle(TO); sendByte(8'h74);
    chk("timeout_to_idle", 4'b0000);
    sendByte(8'hE0); idle(TO - 1); sendByte(8'h74);
    chk("byte_beats_timeout", 4'b0100);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
    chk("right_release2", 4'b0000);
    sendByte(8'hE0); sendByte(8'h6B);
    chk("left_before_reset", 4'b1000);
    sendByte(8'hE0);
    bus.byteIn = 8'hF0;
    bus.byteValid = 1'b1;
    #2 resetN = 1'b0;
    #1 chk("async_reset", 4'b0000);
    bus.byteValid = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    idle(1);
    sendByte(8'h6B);
    chk("prefix_discarded", 4'b0000);
    sendByte(8'hE0);
    resetN = 1'b0;
    idle(1);
    resetN = 1'b1;
    sendByte(8'h74);
    chk("reset_mid_ext", 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 Parameter LEFT_CODE, default 8'h6B, E0-extended scan code of the left arrow.
REQ-002 Parameter RIGHT_CODE, default 8'h74, E0-extended scan code of the right arrow.
REQ-003 Parameter START_CODE, default 8'h5A, non-extended scan code of Enter.
REQ-004 Parameter SHOOT_CODE, default 8'h29, non-extended scan code of Space.
REQ-005 Parameter TIMEOUT_CYCLES, default 50000, maximum idle cycles allowed inside a prefix sequence.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 resetN  input  1  asynchronous, active-low reset.
REQ-008 byteIn  input  8  received PS/2 scan-code byte; valid only when byteValid=1.
REQ-009 byteValid  input  1  single-cycle strobe; one byte consumed per high cycle.
REQ-010 leftPress  output  1  level, left movement request to the character mover.
REQ-011 rightPress  output  1  level, right movement request to the character mover.
REQ-012 startPulse  output  1  one-cycle pulse on a fresh Enter press.
REQ-013 shootPulse  output  1  one-cycle pulse on a fresh Space press.

Function
REQ-014 The prefix FSM SHALL have states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-015 In IDLE: byte E0 -> EXT; byte F0 -> BRK; any other byte is a non-extended make code; stay IDLE.
REQ-016 In EXT: F0 -> EXT_BRK; E0 -> stay EXT and restart the timeout; any other byte is an extended make code; -> IDLE.
REQ-017 In BRK: any byte is a non-extended break code; -> IDLE.
REQ-018 In EXT_BRK: any byte is an extended break code; -> IDLE.
REQ-019 Internal held flags leftHeld, rightHeld, startHeld, shootHeld and a direction flag lastDir (LEFT/RIGHT) SHALL be kept.
REQ-020 Extended make of LEFT_CODE sets leftHeld and lastDir=LEFT. Extended make of RIGHT_CODE sets rightHeld and lastDir=RIGHT.
REQ-021 Extended break of LEFT_CODE or RIGHT_CODE clears the matching held flag.
REQ-022 Non-extended LEFT_CODE/RIGHT_CODE (keypad keys) and extended START_CODE/SHOOT_CODE SHALL be ignored.
REQ-023 Non-extended make of START_CODE with startHeld=0 sets startHeld and drives startPulse=1 for exactly one cycle.
REQ-024 Non-extended make of START_CODE with startHeld=1 (typematic repeat) produces no pulse.
REQ-025 Non-extended break of START_CODE clears startHeld.
REQ-026 SHOOT_CODE SHALL follow REQ-023..REQ-025 with shootHeld and shootPulse.
REQ-027 leftPress = leftHeld AND (NOT rightHeld OR lastDir=LEFT); rightPress = rightHeld AND (NOT leftHeld OR lastDir=RIGHT).
REQ-028 leftPress and rightPress SHALL never both be 1.
REQ-029 All outputs SHALL be registered and SHALL reflect a byte sampled at clock edge k from edge k onward (visible in cycle k+1).
REQ-030 A typematic repeat make of a held arrow SHALL re-assert lastDir for that arrow.
REQ-031 Timeout: in any state other than IDLE, a 16-bit counter SHALL increment each cycle with byteValid=0 and clear on byteValid=1.
REQ-032 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, the counter SHALL clear, and no flag SHALL change.
REQ-033 In IDLE the counter SHALL be held at 0.
REQ-034 A byteValid arriving in the same cycle as the timeout SHALL take priority and be decoded normally.

Reset
REQ-035 resetN=0 SHALL immediately force FSM=IDLE, counter=0, all held flags=0, lastDir=RIGHT, and all four outputs=0.
REQ-036 Reset mid-sequence (e.g. after E0) SHALL discard the prefix; the next byte after release is decoded from IDLE.

Verification
REQ-037 Bytes E0,74 -> rightPress=1 one cycle after the 74 strobe; then E0,F0,74 -> rightPress=0.
REQ-038 E0,6B; E0,74; E0,F0,74 -> leftPress=1; then rightPress=1, leftPress=0; then leftPress=1, rightPress=0.
REQ-039 5A,5A,5A (typematic), F0,5A, 5A -> startPulse exactly twice, each 1 cycle wide.
REQ-040 E0 followed by TIMEOUT_CYCLES idle cycles, then 74 -> FSM back in IDLE, 74 treated as non-extended, rightPress stays 0.
REQ-041 Bytes 6B (no E0), then E0,5A -> leftPress=0 and startPulse=0.
REQ-042 E0,6B, then resetN pulsed low during F0 of the break -> all outputs 0 asynchronously; subsequent 6B alone has no effect.
